// File: rtl/gpu_op_sequencer.sv
// gpu_op_sequencer: frame-level scheduler sharing the GPU op FIFO write port
// among drawing clients, served strictly in index order (painter's algorithm).
package gpu_op_sequencer_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] arg;
    } gpu_op_t;
endpackage

module gpu_op_sequencer
    import gpu_op_sequencer_pkg::*;
#(
    parameter int REQUESTERS  = 3,
    parameter int COUNT_WIDTH = 16,
    localparam int PW = REQUESTERS > 1 ? $clog2(REQUESTERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    output logic [REQUESTERS-1:0]   req_start,
    input  logic [REQUESTERS-1:0]   req_valid,
    input  gpu_op_t [REQUESTERS-1:0] req_op,
    output logic [REQUESTERS-1:0]   req_ack,
    input  logic [REQUESTERS-1:0]   req_done,
    input  logic                    swap,
    output gpu_op_t                 op,
    output logic                    op_wr_en,
    input  logic                    op_full,
    output logic                    frame_ready,
    output logic [PW-1:0]           phase,
    output logic [COUNT_WIDTH-1:0]  frame_op_count
);
    typedef enum logic [2:0] {START, IDLE, WRITE, ACK, WAIT_SWAP} state_t;
    localparam logic [PW-1:0] LAST = PW'(REQUESTERS - 1);
    state_t state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= START;
            phase          <= '0;
            op             <= '0;
            op_wr_en       <= 1'b0;
            req_start      <= '0;
            req_ack        <= '0;
            frame_ready    <= 1'b0;
            frame_op_count <= '0;
        end else if (ce) begin
            // every pulse output lives for exactly one ce cycle unless re-set below
            req_start   <= '0;
            req_ack     <= '0;
            op_wr_en    <= 1'b0;
            frame_ready <= 1'b0;
            case (state)
                START: begin
                    req_start[phase] <= 1'b1;
                    state            <= IDLE;
                end
                IDLE: begin
                    if (req_valid[phase]) begin
                        op    <= req_op[phase];
                        state <= WRITE;
                    end else if (req_done[phase]) begin
                        if (phase == LAST) begin
                            frame_ready <= 1'b1;
                            state       <= WAIT_SWAP;
                        end else begin
                            phase <= phase + PW'(1);
                            state <= START;
                        end
                    end
                end
                WRITE: begin
                    if (!op_full) begin
                        op_wr_en       <= 1'b1;
                        req_ack[phase] <= 1'b1;
                        frame_op_count <= &frame_op_count ? frame_op_count
                                                          : frame_op_count + COUNT_WIDTH'(1);
                        state          <= ACK;
                    end
                end
                ACK: state <= IDLE;
                WAIT_SWAP: begin
                    if (swap) begin
                        phase          <= '0;
                        frame_op_count <= '0;
                        state          <= START;
                    end
                end
                default: state <= START;
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_op_sequencer.sv
// tb_gpu_op_sequencer: scoreboard bench; client models push expected FIFO
// writes in draw order, a negedge monitor pops and compares them.
module tb_gpu_op_sequencer;
    import gpu_op_sequencer_pkg::*;
    localparam int N = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst, ce, swap, op_full;
    logic [N-1:0] req_start, req_valid, req_ack, req_done;
    gpu_op_t [N-1:0] req_op;
    gpu_op_t op;
    logic op_wr_en, frame_ready;
    logic [1:0] phase;
    logic [CW-1:0] frame_op_count;

    always #5 clk = ~clk;

    gpu_op_sequencer #(.REQUESTERS(N), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_start(req_start), .req_valid(req_valid), .req_op(req_op),
        .req_ack(req_ack), .req_done(req_done), .swap(swap),
        .op(op), .op_wr_en(op_wr_en), .op_full(op_full),
        .frame_ready(frame_ready), .phase(phase), .frame_op_count(frame_op_count)
    );

    typedef struct {
        gpu_op_t op;
        int      c;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_start[$];
    int  checks = 0;
    int  passed = 0;
    int  nops[N];
    bit  done_early[N];
    int  idx[N];
    int  frm = 0;
    int  fr_cnt = 0;
    int  wr_pulses;
    logic ce_e = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic gpu_op_t mk(input int c, input int k);
        return gpu_op_t'({8'(frm), 8'(c), 8'(k), 8'h5A});
    endfunction

    task automatic present(input int c);
        if (idx[c] < nops[c]) begin
            req_valid[c] = 1'b1;
            req_op[c]    = mk(c, idx[c]);
            req_done[c]  = done_early[c] && idx[c] == nops[c] - 1;
        end else begin
            req_valid[c] = 1'b0;
            req_done[c]  = 1'b1;
        end
    endtask

    task automatic setup_frame();
        for (int c = 0; c < N; c++) begin
            exp_start.push_back(c);
            for (int k = 0; k < nops[c]; k++) exp_wr.push_back('{mk(c, k), c});
        end
    endtask

    task automatic wait_frame_ready(input string tag);
        int n = 0;
        while (!frame_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, frame_ready, 1);
    endtask

    always @(posedge clk) ce_e = ce;

    // client models
    initial forever begin
        @(negedge clk);
        if (!rst && ce_e) begin
            for (int c = 0; c < N; c++) begin
                if (req_start[c]) begin
                    idx[c] = 0;
                    present(c);
                end else if (req_ack[c]) begin
                    idx[c]++;
                    present(c);
                end
            end
        end
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst && ce_e) begin
            if (req_start != '0) begin
                if (exp_start.size() == 0) check("start_extra", exp_start.size(), 1);
                else check("start_order", req_start, 64'(1) << exp_start.pop_front());
            end
            if (op_wr_en) begin
                if (exp_wr.size() == 0) check("wr_extra", exp_wr.size(), 1);
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_op", op, w.op);
                    check("wr_ack", req_ack, 64'(1) << w.c);
                    check("wr_phase", phase, w.c);
                end
            end else if (req_ack != '0) check("ack_no_wr", req_ack, 0);
            if (frame_ready) fr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ce = 1'b0; swap = 1'b0; op_full = 1'b0;
        req_valid = '0; req_done = '0; req_op = '0;
        for (int c = 0; c < N; c++) begin nops[c] = 2; done_early[c] = 0; idx[c] = 0; end
        #12;
        check("rst_start", req_start, 0);
        check("rst_wr_en", op_wr_en, 0);
        check("rst_ack", req_ack, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_count", frame_op_count, 0);
        check("rst_phase", phase, 0);
        check("rst_op", op, 0);

        // frame 1: plain in-order service
        frm = 1;
        setup_frame();
        @(negedge clk);
        rst = 1'b0; ce = 1'b1;
        wait_frame_ready("f1_ready");
        check("f1_count", frame_op_count, 6);
        check("f1_phase", phase, 2);
        repeat (4) @(negedge clk);
        check("f1_ready_once", fr_cnt, 1);
        check("f1_wr_left", exp_wr.size(), 0);
        check("f1_start_left", exp_start.size(), 0);
        check("f1_hold_phase", phase, 2);

        // frame 2: FIFO stall, early client 1, valid+done together, stray swap
        frm = 2;
        done_early[0] = 1;
        setup_frame();
        req_valid[1] = 1'b1;
        req_op[1] = mk(1, 0);
        op_full = 1'b1;
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        check("swap_count_clr", frame_op_count, 0);
        check("swap_no_start_yet", req_start, 0);
        @(negedge clk);
        check("swap_start", req_start, 1);
        @(negedge clk);
        check("stall_op", op, mk(0, 0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_wr_en", op_wr_en, 0);
            check("stall_op_hold", op, mk(0, 0));
            if (i == 3) swap = 1'b1;
            if (i == 4) swap = 1'b0;
        end
        op_full = 1'b0;
        wr_pulses = 0;
        @(negedge clk);
        check("unstall_wr_en", op_wr_en, 1);
        @(negedge clk);
        check("unstall_pulse", op_wr_en, 0);
        wait_frame_ready("f2_ready");
        check("f2_count", frame_op_count, 6);
        repeat (3) @(negedge clk);
        check("f2_ready_once", fr_cnt, 2);
        check("f2_wr_left", exp_wr.size(), 0);
        done_early[0] = 0;

        // frame 3: async reset mid-WRITE, then ce freeze
        frm = 3;
        setup_frame();
        op_full = 1'b1;
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", op_wr_en, 0);
        check("arst_ack", req_ack, 0);
        check("arst_op", op, 0);
        check("arst_phase", phase, 0);
        check("arst_count", frame_op_count, 0);
        exp_wr.delete();
        exp_start.delete();
        req_valid = '0; req_done = '0; op_full = 1'b0;
        setup_frame();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_start", req_start, 1);
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("freeze_start", req_start, 1);
            check("freeze_wr_en", op_wr_en, 0);
        end
        ce = 1'b1;
        wait_frame_ready("f3_ready");
        check("f3_count", frame_op_count, 6);
        check("f3_wr_left", exp_wr.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/gpu_op_sequencer.md
Name: gpu_op_sequencer

Overview:
- Frame-level scheduler that shares the single GPU op FIFO write port among REQUESTERS drawing clients (background/bird, pipes, score, ...).
- Serves clients in strict index order per frame, preserving painter's-algorithm draw order.
- Kicks each client with a start pulse and forwards its ops one at a time into the FIFO.
- After the last client finishes, reports frame completion and holds until the display swap.

Parameters:
REQUESTERS, 3, number of drawing clients; phase order = index order 0..REQUESTERS-1
COUNT_WIDTH, 16, width of the per-frame op counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ce  input  1  clock enable; all non-reset state updates gated by ce
req_start  output  REQUESTERS  one-cycle pulse: client i may begin its frame
req_valid  input  REQUESTERS  client i presents an op on req_op[i]
req_op  input  REQUESTERS x gpu_op_t  per-client op
req_ack  output  REQUESTERS  one-cycle pulse: req_op[i] written to FIFO
req_done  input  REQUESTERS  level: client i has no more ops this frame; held until its next req_start
swap  input  1  display buffer swap pulse
op  output  gpu_op_t  op to GPU FIFO
op_wr_en  output  1  FIFO write strobe
op_full  input  1  FIFO full
frame_ready  output  1  one-cycle pulse: all clients done for this frame
phase  output  max(1,$clog2(REQUESTERS))  index of the client currently being served
frame_op_count  output  COUNT_WIDTH  ops written since last swap

Behaviour:
- Reset (async, rst=1): state=START, phase=0, op='0, op_wr_en=0, req_start='0, req_ack='0, frame_ready=0, frame_op_count=0. Reset mid-operation abandons the current op; no ack is issued. The first ce cycle after release pulses req_start[0].
- States: START, IDLE, WRITE, ACK, WAIT_SWAP. With ce=0, hold all registers; pulse outputs also hold.
- START: req_start[phase]<=1; next IDLE. req_start is cleared on the next ce cycle.
- IDLE:
  - if req_valid[phase]: op<=req_op[phase]; next WRITE.
  - else if req_done[phase]: if phase==REQUESTERS-1, frame_ready<=1 and next WAIT_SWAP; else phase<=phase+1 and next START.
  - else stay.
  - req_valid has priority over req_done when both are high.
- WRITE: if !op_full, op_wr_en<=1, req_ack[phase]<=1, frame_op_count increments (saturates at all-ones), next ACK. If op_full, stay; op stays stable.
- ACK: op_wr_en<=0, req_ack<='0; next IDLE.
- Timing and throughput:
  - Latency is valid sampled in IDLE at cycle N, then op_wr_en/req_ack high at N+2 when FIFO not full.
  - Peak rate is one op per 3 ce cycles.
  - Exactly one FIFO write per ack.
- Client rules:
  - Hold req_valid/req_op stable until ack.
  - A new op may be presented the cycle after ack; it is sampled at the next IDLE cycle.
- WAIT_SWAP: frame_ready<=0 after one cycle. On swap: phase<=0, frame_op_count<=0, next START.
- Ignored inputs:
  - swap in any other state is ignored, not latched.
  - req_valid/req_done of non-current clients are ignored; such clients never get ack.
- REQUESTERS=1: phase is always 0; frame_ready follows client 0 done.
- op changes only on the IDLE-to-WRITE transition; it holds its last value otherwise.

Test Plan:
- Reset release, ce=1, clients 0..2 each issue 2 ops then done -> req_start pulses in order 0,1,2; FIFO receives 6 ops in client order; frame_ready pulses once; frame_op_count=6; phase=2.
- op_full high 10 cycles while client 0 is in WRITE -> op_wr_en stays 0 for those cycles; it pulses exactly once 1 cycle after op_full falls; op is unchanged throughout.
- Client 1 asserts req_valid during phase 0 -> no ack to client 1 and no FIFO write of its op until phase 1 begins; then its op is written.
- req_valid[0] and req_done[0] high together -> the op is written first; the phase advances only after valid drops.
- Swap pulsed before frame_ready -> ignored; swap after frame_ready -> req_start[0] pulses 2 cycles later; frame_op_count=0.
- rst asserted asynchronously mid-WRITE -> outputs go to 0 immediately, no ack; after release req_start[0] pulses; ce=0 for 5 cycles freezes the state.
